// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive path: framer FSM states, sample width,
// default frame header and bit timing shared with the receiver.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FULL = 2'd3
  } framer_state_t;

  localparam int          SAMPLE_W       = 16;
  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;
  localparam int          CLKS_PER_BIT   = 434;

endpackage

// File: rtl/sample_ram.sv
// Frame buffer: one synchronous write port, one registered read port.
// The array itself has no reset so it maps onto block RAM; only the read register resets.
module sample_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clock,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_clr) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_sample_framer.sv
// Aligns the received byte stream on a header byte, packs little-endian byte pairs
// into 16-bit samples and holds one complete frame until the FFT stage acknowledges it.
module uart_sample_framer
  import uart_frame_pkg::*;
#(
  parameter int         N_SAMPLES   = 256,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         GAP_TIMEOUT = 43400,
  parameter int         AW          = $clog2(N_SAMPLES)
) (
  input  logic                clock,
  input  logic                clr,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                frame_ready,
  input  logic                frame_ack,
  output logic [AW:0]         sample_count,
  output logic                overrun,
  output logic                resync,
  output logic [1:0]          dbg_state
);

  // Handshakes: rx_valid is a one-cycle strobe with no backpressure (a byte is consumed
  // in the cycle it is offered); frame_ready stays high until frame_ack is seen in FULL.

  localparam int          TW      = $clog2(GAP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_V = TW'(GAP_TIMEOUT);
  localparam logic [AW:0] LAST_V  = (AW + 1)'(N_SAMPLES - 1);

  framer_state_t r_state;
  logic [AW:0]   r_count;
  logic [7:0]    r_low;
  logic [TW-1:0] r_timer;
  logic          r_overrun;
  logic          r_resync;

  logic                w_timeout;
  logic                w_we;
  logic [SAMPLE_W-1:0] w_wdata;

  assign w_timeout = (r_timer == TMO_V);
  assign w_we      = (r_state == HI) && rx_valid;
  assign w_wdata   = {rx_data, r_low};

  always_ff @(posedge clock) begin
    if (clr) begin
      r_state   <= SYNC;
      r_count   <= '0;
      r_low     <= '0;
      r_timer   <= '0;
      r_overrun <= 1'b0;
      r_resync  <= 1'b0;
    end else begin
      r_resync <= 1'b0;
      case (r_state)
        SYNC: begin
          r_timer <= '0;
          if (rx_valid && (rx_data == HEADER)) begin
            r_state <= LO;
            r_count <= '0;
          end
        end
        LO, HI: begin
          // A byte in the same cycle as the timeout wins and reloads the timer.
          if (rx_valid) begin
            r_timer <= '0;
            if (r_state == LO) begin
              r_low   <= rx_data;
              r_state <= HI;
            end else begin
              r_count <= r_count + 1'b1;
              r_state <= (r_count == LAST_V) ? FULL : LO;
            end
          end else if (w_timeout) begin
            r_state  <= SYNC;
            r_count  <= '0;
            r_timer  <= '0;
            r_resync <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FULL: begin
          r_timer <= '0;
          if (rx_valid) r_overrun <= 1'b1;
          if (frame_ack) begin
            r_state <= SYNC;
            r_count <= '0;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  sample_ram #(
    .DEPTH(N_SAMPLES),
    .W    (SAMPLE_W),
    .AW   (AW)
  ) u_ram (
    .i_clock(clock),
    .i_clr  (clr),
    .i_we   (w_we),
    .i_waddr(r_count[AW-1:0]),
    .i_wdata(w_wdata),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );

  assign frame_ready  = (r_state == FULL);
  assign sample_count = r_count;
  assign overrun      = r_overrun;
  assign resync       = r_resync;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer with N_SAMPLES=4, GAP_TIMEOUT=20.
// Buffer reads go through an expected-value queue checked by a separate monitor.
module tb_uart_sample_framer;
  import uart_frame_pkg::*;

  localparam int N  = 4;
  localparam int GT = 20;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          clr = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;
  logic          frame_ready;
  logic          frame_ack = 1'b0;
  logic [AW:0]   sample_count;
  logic          overrun;
  logic          resync;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int resync_cnt = 0;

  logic        rd_req = 1'b0;
  logic        rd_req_d = 1'b0;
  logic [15:0] exp_q[$];

  uart_sample_framer #(
    .N_SAMPLES  (N),
    .HEADER     (8'hA5),
    .GAP_TIMEOUT(GT)
  ) dut (
    .clock       (clock),
    .clr         (clr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .sample_count(sample_count),
    .overrun     (overrun),
    .resync      (resync),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a read issued in cycle t is compared after edge t+1
  always @(posedge clock) rd_req_d <= rd_req;

  always @(negedge clock) begin
    if (resync) resync_cnt++;
    if (rd_req_d) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_data: got %h with no expected value queued", rd_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  // Driver tasks: inputs change #1 after the rising edge
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic read_frame(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      exp_q.push_back(e[a]);
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_sample_count"}, 32'(sample_count), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_resync"}, 32'(resync), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(SYNC));
  endtask

  initial begin
    int r0;
    // Reset
    clr = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    clr = 1'b0;
    tick();

    // Basic frame with extreme sample values
    send_byte(8'hA5);
    check("hdr_state", 32'(dbg_state), 32'(LO));
    send_byte(8'h34); send_byte(8'h12);
    check("count_after_first", 32'(sample_count), 32'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'hFF); send_byte(8'h7F);
    send_byte(8'h00);
    check("ready_before_last", 32'(frame_ready), 32'd0);
    send_byte(8'h80);
    check("ready_after_last", 32'(frame_ready), 32'd1);
    check("count_full", 32'(sample_count), 32'd4);
    read_frame(16'h1234, 16'h5678, 16'h7FFF, 16'h8000);

    // Byte in FULL sets overrun and leaves the buffer alone
    send_byte(8'h22);
    check("overrun_set", 32'(overrun), 32'd1);
    check("count_held_full", 32'(sample_count), 32'd4);
    check("still_full", 32'(frame_ready), 32'd1);
    read_frame(16'h1234, 16'h5678, 16'h7FFF, 16'h8000);
    ack();
    check("ack_ready", 32'(frame_ready), 32'd0);
    check("ack_state", 32'(dbg_state), 32'(SYNC));
    check("ack_count", 32'(sample_count), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Pre-header bytes are ignored
    send_byte(8'h00); send_byte(8'h11);
    check("prehdr_state", 32'(dbg_state), 32'(SYNC));
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h80); send_byte(8'hA5); send_byte(8'h12);
    check("f2_ready", 32'(frame_ready), 32'd1);
    read_frame(16'h0001, 16'hFFFF, 16'h8000, 16'h12A5);
    ack();

    // clr mid-frame
    send_byte(8'hA5); send_byte(8'h01);
    clr = 1'b1;
    tick();
    check_reset_outputs("midclr");
    clr = 1'b0;
    send_byte(8'hA5);
    send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h01); send_byte(8'h80);
    send_byte(8'hFE); send_byte(8'h7F); send_byte(8'h00); send_byte(8'h00);
    check("f3_ready", 32'(frame_ready), 32'd1);
    read_frame(16'hABCD, 16'h8001, 16'h7FFE, 16'h0000);
    ack();

    // Gap timeout: fires on the 21st idle edge
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("tmo_count_before", 32'(sample_count), 32'd1);
    r0 = resync_cnt;
    repeat (20) @(posedge clock);
    #1;
    check("tmo_not_yet_state", 32'(dbg_state), 32'(HI));
    check("tmo_not_yet_resync", 32'(resync), 32'd0);
    tick();
    check("tmo_resync", 32'(resync), 32'd1);
    check("tmo_state", 32'(dbg_state), 32'(SYNC));
    check("tmo_count", 32'(sample_count), 32'd0);
    tick();
    check("tmo_resync_low", 32'(resync), 32'd0);
    check("tmo_one_pulse", 32'(resync_cnt - r0), 32'd1);
    check("tmo_overrun_clear", 32'(overrun), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("f4_ready", 32'(frame_ready), 32'd1);
    read_frame(16'h2211, 16'h4433, 16'h6655, 16'h8877);

    // Byte and ack together in FULL: ack wins, byte is not a header
    rx_data   = 8'hA5;
    rx_valid  = 1'b1;
    frame_ack = 1'b1;
    tick();
    rx_valid  = 1'b0;
    frame_ack = 1'b0;
    check("sim_state", 32'(dbg_state), 32'(SYNC));
    check("sim_overrun", 32'(overrun), 32'd1);
    check("sim_ready", 32'(frame_ready), 32'd0);
    send_byte(8'h01); send_byte(8'h02);
    check("sim_ignored_state", 32'(dbg_state), 32'(SYNC));
    check("sim_ignored_count", 32'(sample_count), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    check("sim_resumed_count", 32'(sample_count), 32'd1);
    check("sim_resumed_state", 32'(dbg_state), 32'(LO));

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_sample_framer.md
# uart_sample_framer

Downstream consumer of the UART receiver. Takes the received byte stream, aligns on a header byte, packs byte pairs into signed 16-bit samples, and stores one frame of `N_SAMPLES` samples in an internal buffer. When the frame is complete it holds the buffer for the FFT stage to read, then releases it on an acknowledge.

## Interface
- `N_SAMPLES`, 256: samples per frame; power of two, ≥2.
- `HEADER`, 8'hA5: frame-start byte.
- `GAP_TIMEOUT`, 43400: idle clocks allowed between bytes inside a frame (≈10 byte times at 434 clocks/bit).
- `AW`, derived `$clog2(N_SAMPLES)`; not overridden.

Ports:
- `clock  in  1`  system clock; the only clock.
- `clr  in  1`  reset, synchronous, active-high.
- `rx_data  in  8`  received byte.
- `rx_valid  in  1`  one-cycle strobe; `rx_data` is valid in that cycle.
- `rd_addr  in  AW`  sample read address from the FFT stage.
- `rd_data  out  16`  registered sample at `rd_addr`.
- `frame_ready  out  1`  buffer holds a complete frame.
- `frame_ack  in  1`  FFT stage done; releases the buffer.
- `sample_count  out  AW+1`  samples written in the current frame.
- `overrun  out  1`  sticky; a byte arrived while in FULL.
- `resync  out  1`  one-cycle pulse; a partial frame was dropped on timeout.

## Operation
- States: SYNC, LO, HI, FULL. Reset state is SYNC.
- SYNC:
  - `rx_valid && rx_data==HEADER` → LO, `sample_count<=0`.
  - Any other byte is discarded.
- LO: `rx_valid` → latch the low byte, go to HI.
- HI: `rx_valid` → write `{rx_data, low}` to `mem[sample_count]` and increment `sample_count`.
  - Next state is FULL if `sample_count==N_SAMPLES-1` before the increment, otherwise LO.
- FULL:
  - `frame_ready=1`.
  - `rx_valid` bytes are discarded and set `overrun`.
  - `frame_ack` → SYNC, clears `sample_count`.
- `frame_ack` is ignored outside FULL.
- Header bytes inside LO/HI are data; there is no in-frame realignment.
- Samples are little-endian and two's complement, stored unmodified. `HEADER` has no escaping.
- Gap timer:
  - Counts clocks in LO/HI and reloads to 0 on every `rx_valid`.
  - When it reaches `GAP_TIMEOUT` with no `rx_valid` that cycle: go to SYNC, set `sample_count<=0`, pulse `resync`.
  - The timer is held at 0 in SYNC and FULL. Counter width is `$clog2(GAP_TIMEOUT+1)`.
- Simultaneous events:
  - `rx_valid` and `frame_ack` in FULL: the ack takes effect, the byte is discarded and `overrun` is set. The byte is not checked against `HEADER`.
  - `rx_valid` and timeout in the same cycle: the byte wins and the timer reloads.
- Read port: `rd_data <= mem[rd_addr]` every cycle in every state. Contents are only guaranteed coherent while `frame_ready=1`.
- `clr` mid-operation:
  - Returns to SYNC.
  - All outputs go to their reset values and `overrun` clears.
  - Memory contents are not cleared.

## Timing
- Reset values:
  - `frame_ready=0`, `sample_count=0`, `overrun=0`, `resync=0`, `rd_data=0`.
  - Internal low-byte register and gap timer also reset to 0.
- Write latency: a sample is in memory, and `sample_count` is updated, the cycle after the HI `rx_valid`.
- `frame_ready` rises the cycle after the final HI `rx_valid` and falls the cycle after `frame_ack`.
- Read latency is 1 clock: `rd_addr` presented in cycle t gives `rd_data` in t+1.
- `resync` is high for exactly the one cycle after the timeout cycle.
- `rx_valid` strobes may arrive on back-to-back clocks; no bytes are lost outside FULL.
- No combinational path from any input to any output.

## Structure
- Shared package `uart_frame_pkg`:
  - state typedef `framer_state_t` (SYNC, LO, HI, FULL);
  - `SAMPLE_W=16`;
  - `DEFAULT_HEADER=8'hA5`;
  - `CLKS_PER_BIT=434`, also reused by the receiver.
- Sub-module `sample_ram`: `N_SAMPLES x 16`, one synchronous write port and one registered read port, no reset on the array, block-RAM inferable.
- Top level holds the FSM, the gap timer and the low-byte register.

## Test plan
Bench uses `N_SAMPLES=4` and `GAP_TIMEOUT=20`.
- Bytes A5,34,12,78,56,FF,7F,00,80 → `frame_ready` rises after the last byte. Reading addresses 0..3 returns 1234, 5678, 7FFF, 8000, each one clock after its address; `sample_count=4`.
- Bytes 00,11,A5 then a full frame → pre-header bytes are ignored and the frame matches the sent data.
- In FULL, send byte 22 → `overrun=1`, buffer unchanged. Then `frame_ack` → `frame_ready=0` next cycle and the state is SYNC.
- A5,01,02,03 then 21 idle clocks → `resync` pulses once, `sample_count=0`. A new frame is then accepted correctly.
- `rx_valid` and `frame_ack` in the same FULL cycle with byte A5 → state SYNC, `overrun=1`. Following bytes 01,02 are not stored until a new A5 arrives.
- `clr` asserted mid-frame after A5,01 → next cycle all outputs are at reset values. A fresh frame then completes normally.
